// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared constants for the multi-cycle datapath: opcode and
//             funct codes, the 3-bit ALU operation encoding, the FSM state
//             encoding and two small decode helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

   // Primary opcodes (instruction bits 31:26)
   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_addi  = 6'h08;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_j     = 6'h02;

   // R-type funct codes (instruction bits 5:0)
   localparam logic [5:0] c_fn_add = 6'h20;
   localparam logic [5:0] c_fn_sub = 6'h22;
   localparam logic [5:0] c_fn_and = 6'h24;
   localparam logic [5:0] c_fn_or  = 6'h25;
   localparam logic [5:0] c_fn_slt = 6'h2A;

   // ALU operation encoding
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_t;

   // FSM state encoding (also exported on state_o)
   localparam logic [2:0] c_s_fetch  = 3'd0;
   localparam logic [2:0] c_s_decode = 3'd1;
   localparam logic [2:0] c_s_exec   = 3'd2;
   localparam logic [2:0] c_s_mem    = 3'd3;
   localparam logic [2:0] c_s_wb     = 3'd4;
   localparam logic [2:0] c_s_halt   = 3'd7;

   function automatic logic funct_is_legal(input logic [5:0] fn);
      return (fn == c_fn_add) || (fn == c_fn_sub) || (fn == c_fn_and) ||
             (fn == c_fn_or)  || (fn == c_fn_slt);
   endfunction

   function automatic alu_op_t funct_to_alu(input logic [5:0] fn);
      alu_op_t op;
      case (fn)
         c_fn_sub: op = ALU_SUB;
         c_fn_and: op = ALU_AND;
         c_fn_or:  op = ALU_OR;
         c_fn_slt: op = ALU_SLT;
         default:  op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : mc_regfile
//  Purpose  : 2^REG_AW x DATA_W register file, two combinational read ports
//             and one synchronous write port. Register 0 always reads zero
//             and ignores writes. Contents are not reset.
//  Ports    : clk            - rising-edge clock
//             we/waddr/wdata - write port
//             raddr0/rdata0  - read port 0 (combinational)
//             raddr1/rdata1  - read port 1 (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module mc_regfile #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr0,
   output logic [DATA_W-1:0] rdata0,
   input  logic [REG_AW-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1
);

   logic [DATA_W-1:0] r_regs [0:(2**REG_AW)-1];

   always_ff @(posedge clk) begin
      if (we && (waddr != '0)) begin
         r_regs[waddr] <= wdata;
      end
   end

   // Entry 0 is never written, so the zero is forced on the read side.
   assign rdata0 = (raddr0 == '0) ? '0 : r_regs[raddr0];
   assign rdata1 = (raddr1 == '0) ? '0 : r_regs[raddr1];

endmodule
`default_nettype wire

// File: rtl/mc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : mc_datapath
//  Purpose  : Multi-cycle datapath. Five-phase controller (fetch, decode,
//             execute, memory, write-back) with one shared ALU and one
//             unified memory port using a req/ready handshake.
//  Ports    : Clock      - rising-edge clock
//             Reset      - asynchronous active-low reset
//             mem_req    - memory request valid
//             mem_we     - 1 = write, 0 = read
//             mem_addr   - byte address
//             mem_wdata  - store data
//             mem_rdata  - read data, sampled on the completing cycle
//             mem_ready  - memory accepts/completes the request
//             instr_done - one-cycle pulse on instruction retire
//             halt       - sticky, set by an illegal opcode or funct
//             state_o    - current FSM state
//  Config   : MC_JUMP_EN - when defined, j (op 0x02) is executed; otherwise
//             it is treated as an illegal opcode.
//  Revision : 1.0  initial release
// ============================================================================
module mc_datapath
   import mc_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                REG_AW   = 5,
   parameter logic [DATA_W-1:0] PC_RESET = '0
) (
   input  logic              Clock,
   input  logic              Reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              instr_done,
   output logic              halt,
   output logic [2:0]        state_o
);

   // ---------------------------------------------------------------------
   // Architectural / internal registers
   // ---------------------------------------------------------------------
   logic [2:0]        r_state;
   logic [DATA_W-1:0] r_pc;
   logic [31:0]       r_ir;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_alu_out;
   logic [DATA_W-1:0] r_mdr;

   // ---------------------------------------------------------------------
   // Instruction field decode
   // ---------------------------------------------------------------------
   logic [5:0]        w_op;
   logic [5:0]        w_funct;
   logic [4:0]        w_rs_full, w_rt_full, w_rd_full;
   logic [REG_AW-1:0] w_rs, w_rt, w_rd;
   logic [DATA_W-1:0] w_imm_sext;
   logic              w_is_rtype;
   logic              w_is_jump;
   logic              w_legal;

   assign w_op       = r_ir[31:26];
   assign w_funct    = r_ir[5:0];
   assign w_rs_full  = r_ir[25:21];
   assign w_rt_full  = r_ir[20:16];
   assign w_rd_full  = r_ir[15:11];
   assign w_rs       = w_rs_full[REG_AW-1:0];
   assign w_rt       = w_rt_full[REG_AW-1:0];
   assign w_rd       = w_rd_full[REG_AW-1:0];
   assign w_imm_sext = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
   assign w_is_rtype = (w_op == c_op_rtype);

   always_comb begin
      w_legal = 1'b0;
      case (w_op)
         c_op_rtype:                          w_legal = funct_is_legal(w_funct);
         c_op_addi, c_op_lw, c_op_sw, c_op_beq: w_legal = 1'b1;
`ifdef MC_JUMP_EN
         c_op_j:                              w_legal = 1'b1;
`endif
         default:                             w_legal = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // PC arithmetic
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] w_pc_plus4;
   logic [DATA_W-1:0] w_branch_target;

   assign w_pc_plus4      = r_pc + {{(DATA_W-3){1'b0}}, 3'd4};
   // Decode runs after the PC increment, so this is relative to PC+4.
   assign w_branch_target = r_pc + {w_imm_sext[DATA_W-3:0], 2'b00};

`ifdef MC_JUMP_EN
   logic [DATA_W-1:0] w_jump_target;
   assign w_is_jump     = (w_op == c_op_j);
   assign w_jump_target = {r_pc[DATA_W-1:28], r_ir[25:0], 2'b00};
`else
   assign w_is_jump     = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Shared ALU: R-type uses A op B, every other user needs A + sext(imm)
   // ---------------------------------------------------------------------
   alu_op_t           w_alu_op;
   logic [DATA_W-1:0] w_alu_b;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_slt;

   assign w_alu_op = w_is_rtype ? funct_to_alu(w_funct) : ALU_ADD;
   assign w_alu_b  = w_is_rtype ? r_b : w_imm_sext;
   assign w_slt    = $signed(r_a) < $signed(w_alu_b);

   always_comb begin
      w_alu_res = '0;
      case (w_alu_op)
         ALU_ADD: w_alu_res = r_a + w_alu_b;
         ALU_SUB: w_alu_res = r_a - w_alu_b;
         ALU_AND: w_alu_res = r_a & w_alu_b;
         ALU_OR:  w_alu_res = r_a | w_alu_b;
         ALU_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, w_slt};
         default: w_alu_res = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------
   logic              w_rf_we;
   logic [REG_AW-1:0] w_rf_waddr;
   logic [DATA_W-1:0] w_rf_wdata;
   logic [DATA_W-1:0] w_rs_data;
   logic [DATA_W-1:0] w_rt_data;

   assign w_rf_we    = (r_state == c_s_wb);
   assign w_rf_waddr = w_is_rtype ? w_rd : w_rt;
   assign w_rf_wdata = (w_op == c_op_lw) ? r_mdr : r_alu_out;

   mc_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk    (Clock),
      .we     (w_rf_we),
      .waddr  (w_rf_waddr),
      .wdata  (w_rf_wdata),
      .raddr0 (w_rs),
      .rdata0 (w_rs_data),
      .raddr1 (w_rt),
      .rdata1 (w_rt_data)
   );

   // ---------------------------------------------------------------------
   // Memory port: decoded from registered state only, so it holds steady
   // through wait cycles. Reset gates mem_req directly so it drops at once.
   // ---------------------------------------------------------------------
   logic w_handshake;

   assign mem_req     = Reset && ((r_state == c_s_fetch) || (r_state == c_s_mem));
   assign mem_we      = (r_state == c_s_mem) && (w_op == c_op_sw);
   assign mem_addr    = (r_state == c_s_mem) ? r_alu_out : r_pc;
   assign mem_wdata   = r_b;
   assign w_handshake = mem_req && mem_ready;

   assign instr_done = (r_state == c_s_wb) ||
                       ((r_state == c_s_exec) && ((w_op == c_op_beq) || w_is_jump)) ||
                       ((r_state == c_s_mem) && (w_op == c_op_sw) && w_handshake);
   assign halt       = (r_state == c_s_halt);
   assign state_o    = r_state;

   // ---------------------------------------------------------------------
   // Controller
   // ---------------------------------------------------------------------
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state   <= c_s_fetch;
         r_pc      <= PC_RESET;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_alu_out <= '0;
         r_mdr     <= '0;
      end else begin
         case (r_state)
            c_s_fetch: begin
               if (w_handshake) begin
                  r_ir    <= mem_rdata[31:0];
                  r_pc    <= w_pc_plus4;
                  r_state <= c_s_decode;
               end
            end
            c_s_decode: begin
               if (w_legal) begin
                  r_a       <= w_rs_data;
                  r_b       <= w_rt_data;
                  r_alu_out <= w_branch_target;
                  r_state   <= c_s_exec;
               end else begin
                  r_state <= c_s_halt;
               end
            end
            c_s_exec: begin
               case (w_op)
                  c_op_rtype, c_op_addi: begin
                     r_alu_out <= w_alu_res;
                     r_state   <= c_s_wb;
                  end
                  c_op_lw, c_op_sw: begin
                     r_alu_out <= w_alu_res;
                     r_state   <= c_s_mem;
                  end
                  c_op_beq: begin
                     if (r_a == r_b) begin
                        r_pc <= r_alu_out;
                     end
                     r_state <= c_s_fetch;
                  end
`ifdef MC_JUMP_EN
                  c_op_j: begin
                     r_pc    <= w_jump_target;
                     r_state <= c_s_fetch;
                  end
`endif
                  default: r_state <= c_s_halt;
               endcase
            end
            c_s_mem: begin
               if (w_handshake) begin
                  if (w_op == c_op_lw) begin
                     r_mdr   <= mem_rdata;
                     r_state <= c_s_wb;
                  end else begin
                     r_state <= c_s_fetch;
                  end
               end
            end
            c_s_wb:   r_state <= c_s_fetch;
            c_s_halt: r_state <= c_s_halt;
            default:  r_state <= c_s_halt;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_datapath
//  Purpose  : Self-checking bench for mc_datapath. A reactive memory model
//             with configurable wait states drives the port; an
//             instruction-level model predicts fetch addresses, memory
//             transactions, store data and instruction latencies.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_datapath;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        mem_req, mem_we, mem_ready, instr_done, halt;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  state_o;

   always #5 Clock = ~Clock;

   mc_datapath #(
      .DATA_W   (32),
      .REG_AW   (5),
      .PC_RESET (32'h0)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .instr_done (instr_done),
      .halt       (halt)  ,
      .state_o    (state_o)
   );

   // memory, lazy code generation flags, ISA model
   logic [31:0] mem      [0:4095];
   bit          gen_done [0:4095];
   logic [31:0] m_reg    [0:31];
   logic [31:0] m_pc;
   logic [2:0]  st_log   [0:7];

   int n_checks = 0;
   int n_fail   = 0;
   int wait_cfg = 0;      // <0 : random 0..3 waits per request
   bit rand_code = 1'b0;

   // responder bookkeeping and per-cycle samples
   bit          in_req = 1'b0;
   int          wcnt   = 0;
   logic [31:0] h_addr, h_wdata;
   logic        h_we;
   logic        s_req, s_we, s_done, s_halt, s_hs, s_new;
   logic [31:0] s_addr, s_wdata;
   logic [2:0]  s_state;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock of the memory model: drive at negedge, sample 1 time unit later.
   task automatic drive_cycle();
      @(negedge Clock);
      s_new = 1'b0;
      if (Reset && mem_req) begin
         if (!in_req) begin
            in_req = 1'b1;
            s_new  = 1'b1;
            wcnt   = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
            h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
         end else begin
            check_value("hold_addr",  mem_addr,     h_addr);
            check_value("hold_we",    32'(mem_we),  32'(h_we));
            check_value("hold_wdata", mem_wdata,    h_wdata);
         end
         mem_ready = (wcnt == 0);
      end else begin
         // ready without a request must be ignored
         mem_ready = 1'($urandom_range(0, 1));
      end
      mem_rdata = mem[mem_addr[13:2]];
      #1;
      s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
      s_done = instr_done; s_halt = halt; s_state = state_o;
      s_hs = s_req && mem_ready;
      if (s_hs) begin
         in_req = 1'b0;
         if (s_we) mem[s_addr[13:2]] = s_wdata;
      end else if (s_req) begin
         wcnt--;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      int          k  = int'($urandom_range(0, 9));
      logic [4:0]  rs = 5'($urandom_range(0, 7));
      logic [4:0]  rt = 5'($urandom_range(0, 7));
      logic [4:0]  rd = 5'($urandom_range(0, 7));
      logic [15:0] off = 16'(32'h2000 + 4 * $urandom_range(0, 255));
      logic [5:0]  fn;
      case ($urandom_range(0, 4))
         0: fn = 6'h20;
         1: fn = 6'h22;
         2: fn = 6'h24;
         3: fn = 6'h25;
         default: fn = 6'h2A;
      endcase
      case (k)
         3, 4, 5: return {6'h00, rs, rt, rd, 5'd0, fn};
         6:       return {6'h2B, 5'd0, rt, off};
         7:       return {6'h23, 5'd0, rt, off};
         8:       return {6'h04, rs & 5'd3, rt & 5'd3, 16'($urandom_range(0, 7))};
         default: return {6'h08, rs, rt, 16'($urandom)};
      endcase
   endfunction

   // Execute one instruction on the model and check the DUT against it.
   task automatic run_instr(output int lat);
      int          idx = int'(m_pc[13:2]);
      logic [31:0] ir, a, b, sx, res, nxt, ea, pc4;
      logic [5:0]  op, fn;
      int          rs, rt, rd, base, cyc, waits, nreq, wreg;
      bit          legal, is_mem, is_st, wr, ended;
      if (rand_code && !gen_done[idx]) begin
         mem[idx] = rand_instr();
         gen_done[idx] = 1'b1;
      end
      ir = mem[idx]; op = ir[31:26]; fn = ir[5:0];
      rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
      a = m_reg[rs]; b = m_reg[rt]; sx = {{16{ir[15]}}, ir[15:0]};
      pc4 = m_pc + 32'd4; nxt = pc4; ea = a + sx;
      legal = 1; is_mem = 0; is_st = 0; wr = 0; wreg = 0; res = 0; base = 4;
      case (op)
         6'h00: begin
            wr = 1; wreg = rd;
            case (fn)
               6'h20: res = a + b;
               6'h22: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: legal = 0;
            endcase
         end
         6'h08: begin wr = 1; wreg = rt; res = a + sx; end
         6'h23: begin base = 5; is_mem = 1; wr = 1; wreg = rt; res = mem[ea[13:2]]; end
         6'h2B: begin is_mem = 1; is_st = 1; end
         6'h04: begin base = 3; if (a == b) nxt = pc4 + (sx << 2); end
`ifdef MC_JUMP_EN
         6'h02: begin base = 3; nxt = {pc4[31:28], ir[25:0], 2'b00}; end
`endif
         default: legal = 0;
      endcase

      cyc = 0; waits = 0; nreq = 0; ended = 0;
      for (int k = 0; k < 80 && !ended; k++) begin
         drive_cycle();
         cyc++;
         if (cyc <= 8) st_log[cyc-1] = s_state;
         if (s_req) begin
            if (s_new && nreq == 0) begin
               check_value("fetch_addr", s_addr, m_pc);
               check_value("fetch_we", 32'(s_we), 32'd0);
            end else if (s_new && nreq == 1) begin
               check_value("data_addr", s_addr, ea);
               check_value("data_we", 32'(s_we), 32'(is_st));
               if (is_st) check_value("store_data", s_wdata, b);
            end
            if (s_hs) nreq++; else waits++;
         end
         if (legal ? s_done : s_halt) ended = 1;
      end
      lat = cyc;
      if (legal) begin
         check_value("latency", cyc, base + waits);
         check_value("req_count", nreq, is_mem ? 2 : 1);
         if (wr && wreg != 0) m_reg[wreg] = res;
         m_pc = nxt;
      end else begin
         check_value("halt_latency", cyc, waits + 3);
         check_value("halt_state", 32'(s_state), 32'd7);
         check_value("halt_req", 32'(s_req), 32'd0);
      end
   endtask

   initial begin
      int lat, cnt;
      bit found;
      mem_ready = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 4096; i++) begin mem[i] = $urandom; gen_done[i] = 1'b0; end
      for (int r = 0; r < 32; r++) m_reg[r] = '0;
      m_pc = 32'h0;

      // directed program
      mem[0]  = 32'h20010005;   // addi $1,$0,5
      mem[1]  = 32'h20010007;   // addi $1,$0,7
      mem[2]  = 32'h20020009;   // addi $2,$0,9
      mem[3]  = 32'h00221822;   // sub  $3,$1,$2
      mem[4]  = 32'h0022202A;   // slt  $4,$1,$2
      mem[5]  = 32'hAC032000;   // sw   $3,0x2000($0)
      mem[6]  = 32'hAC042004;   // sw   $4,0x2004($0)
      mem[7]  = 32'h10210003;   // beq  $1,$1,3 -> 0x2C
      mem[8]  = 32'hFFFFFFFF; mem[9] = 32'hFFFFFFFF; mem[10] = 32'hFFFFFFFF;
      mem[11] = 32'h10220003;   // beq  $1,$2,3 (not taken)
      mem[12] = 32'h20000001;   // addi $0,$0,1
      mem[13] = 32'hAC002008;   // sw   $0,0x2008($0)
      mem[14] = 32'hAC010008;   // sw   $1,8($0)
      mem[15] = 32'h8C050008;   // lw   $5,8($0)
      mem[16] = 32'h8C05200C;   // lw   $5,0x200C($0) (aborted by reset)
      mem[32'h200C >> 2] = 32'hDEADBEEF;

      // reset values
      repeat (3) @(negedge Clock);
      #1;
      check_value("rst_req",   32'(mem_req),    32'd0);
      check_value("rst_we",    32'(mem_we),     32'd0);
      check_value("rst_addr",  mem_addr,        32'h0);
      check_value("rst_wdata", mem_wdata,       32'h0);
      check_value("rst_done",  32'(instr_done), 32'd0);
      check_value("rst_halt",  32'(halt),       32'd0);
      check_value("rst_state", 32'(state_o),    32'd0);
      @(posedge Clock); #2 Reset = 1'b1;
      #1 check_value("first_req", 32'(mem_req), 32'd1);

      // zero-wait directed section
      wait_cfg = 0;
      run_instr(lat);
      check_value("addi_lat", lat, 4);
      check_value("addi_states", {20'd0, st_log[0], 1'b0, st_log[1], 1'b0, st_log[2], 1'b0, st_log[3]},
                  {20'd0, 3'd0, 1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 3'd4});
      for (int i = 1; i <= 7; i++) run_instr(lat);
      for (int i = 0; i < 3; i++) run_instr(lat);
      check_value("mem_sub", mem[32'h2000 >> 2], 32'hFFFFFFFE);
      check_value("mem_slt", mem[32'h2004 >> 2], 32'h1);
      check_value("mem_r0",  mem[32'h2008 >> 2], 32'h0);

      // two wait cycles on every request
      wait_cfg = 2;
      run_instr(lat);
      check_value("sw_wait_lat", lat, 8);
      run_instr(lat);
      check_value("lw_wait_lat", lat, 9);
      check_value("mem_sw8", mem[2], 32'h7);

      // reset asserted during a load's memory wait
      wait_cfg = 6;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         drive_cycle();
         if (s_state == 3'd3 && s_req && !s_hs) found = 1;
      end
      check_value("reached_mem_wait", 32'(found), 32'd1);
      Reset = 1'b0;
      #1;
      check_value("abort_req",   32'(mem_req),    32'd0);
      check_value("abort_state", 32'(state_o),    32'd0);
      check_value("abort_addr",  mem_addr,        32'h0);
      check_value("abort_done",  32'(instr_done), 32'd0);
      in_req = 1'b0;
      for (int i = 0; i < 4096; i++) gen_done[i] = 1'b0;
      mem[0] = 32'hAC052100;    // sw $5,0x2100($0)
      gen_done[0] = 1'b1;
      for (int r = 1; r < 8; r++) begin
         mem[r] = {6'h08, 5'd0, 5'(r), 16'($urandom)};
         gen_done[r] = 1'b1;
      end
      m_pc = 32'h0;
      rand_code = 1'b1;
      wait_cfg = -1;
      @(posedge Clock); #2 Reset = 1'b1;
      run_instr(lat);
      check_value("r5_kept", mem[32'h2100 >> 2], 32'h7);

      // random program with random wait states
      for (int i = 0; i < 300; i++) run_instr(lat);
      for (int r = 1; r < 8; r++) begin
         mem[m_pc[13:2]] = {6'h2B, 5'd0, 5'(r), 16'(32'h2200 + 4 * r)};
         gen_done[m_pc[13:2]] = 1'b1;
         run_instr(lat);
      end

      // illegal opcode: halt is sticky and the port stays quiet
      mem[m_pc[13:2]] = 32'hFC000000;
      gen_done[m_pc[13:2]] = 1'b1;
      run_instr(lat);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         drive_cycle();
         if (s_req) cnt++;
      end
      check_value("halt_quiet", cnt, 0);
      check_value("halt_sticky", 32'(s_halt), 32'd1);
      Reset = 1'b0;
      #1 check_value("halt_cleared", 32'(halt), 32'd0);

      // jump: executes with MC_JUMP_EN, halts without it
      in_req = 1'b0;
      mem[0]  = 32'h08000010;   // j 0x40
      mem[16] = 32'h20010001;   // addi $1,$0,1
      gen_done[0] = 1'b1; gen_done[16] = 1'b1;
      m_pc = 32'h0;
      @(posedge Clock); #2 Reset = 1'b1;
      run_instr(lat);
`ifdef MC_JUMP_EN
      run_instr(lat);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
